// File: rtl/cmd_pkg.sv
// Shared constants for the glitcher byte command protocol and the host-side
// command initiator (opcodes, param codes, response bytes, status, FSM states).
package cmd_pkg;

    localparam logic [7:0] CMD_PING       = 8'h01;
    localparam logic [7:0] CMD_READ       = 8'h02;
    localparam logic [7:0] CMD_WRITE      = 8'h03;
    localparam logic [7:0] CMD_ARM        = 8'h04;
    localparam logic [7:0] CMD_DISARM     = 8'h05;
    localparam logic [7:0] CMD_CHECKSTATE = 8'h06;

    localparam logic [7:0] PARAM_DELAY    = 8'h01;
    localparam logic [7:0] PARAM_WIDTH    = 8'h02;
    localparam logic [7:0] PARAM_COUNT    = 8'h03;
    localparam logic [7:0] PARAM_GAP      = 8'h04;

    localparam logic [7:0] RESP_ACK       = 8'hAA;
    localparam logic [7:0] RESP_NACK      = 8'hFF;

    localparam logic [1:0] RSP_ACK        = 2'd0;
    localparam logic [1:0] RSP_NACK       = 2'd1;
    localparam logic [1:0] RSP_DATA       = 2'd2;
    localparam logic [1:0] RSP_TIMEOUT    = 2'd3;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND        = 3'd1;
    localparam logic [2:0] ST_WAIT_TX     = 3'd2;
    localparam logic [2:0] ST_WAIT_RSP    = 3'd3;
    localparam logic [2:0] ST_REPORT      = 3'd4;

    // READ and WRITE carry param + data; everything else is a bare opcode.
    function automatic logic cmd_is_long(input logic [7:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

    function automatic logic [1:0] classify(input logic [7:0] cmd, input logic [7:0] rsp);
        if (cmd == CMD_READ || cmd == CMD_CHECKSTATE)
            return RSP_DATA;
        else if (rsp == RESP_ACK)
            return RSP_ACK;
        else
            return RSP_NACK;
    endfunction

endpackage

// File: rtl/cmd_timer.sv
// Saturating cycle timer; expire is high while the count sits at TIMEOUT_CYCLES-1.
module cmd_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMEOUT_W      = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count;

    assign expire = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expire)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/cmd_initiator.sv
// Host-side command master: serialises a 1- or 3-byte command, waits for the
// single response byte and reports it as ACK/NACK/DATA/TIMEOUT.
module cmd_initiator
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMEOUT_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_param,
    input  logic [7:0] req_data,
    output logic       tx_strobe,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic       rx_strobe,
    input  logic [7:0] rx_byte,
    output logic       rsp_valid,
    output logic [1:0] rsp_status,
    output logic [7:0] rsp_byte,
    output logic       busy
);

    logic [2:0] state;
    logic       init_done;
    logic [7:0] cmd_q;
    logic [7:0] param_q;
    logic [7:0] data_q;
    logic [1:0] byte_idx;
    logic [1:0] last_idx;
    logic [7:0] next_byte;
    logic       tmr_clear;
    logic       tmr_enable;
    logic       tmr_expire;

    assign busy      = (state != ST_IDLE);
    // Held low for the first cycle after reset release.
    assign req_ready = (state == ST_IDLE) && init_done;
    assign tx_strobe = (state == ST_SEND);
    assign rsp_valid = (state == ST_REPORT);

    assign last_idx  = cmd_is_long(cmd_q) ? 2'd2 : 2'd0;
    assign next_byte = (byte_idx == 2'd0) ? param_q : data_q;

    // One timer serves both waits: restarted at each launch and at the final tx_done.
    assign tmr_clear  = (state == ST_SEND) || (state == ST_WAIT_TX && tx_done);
    assign tmr_enable = (state == ST_WAIT_TX) || (state == ST_WAIT_RSP);

    cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .enable(tmr_enable),
        .expire(tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            init_done  <= 1'b0;
            cmd_q      <= '0;
            param_q    <= '0;
            data_q     <= '0;
            byte_idx   <= '0;
            tx_byte    <= '0;
            rsp_status <= RSP_ACK;
            rsp_byte   <= '0;
        end else begin
            init_done <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cmd_q    <= req_cmd;
                        param_q  <= req_param;
                        data_q   <= req_data;
                        byte_idx <= 2'd0;
                        tx_byte  <= req_cmd;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: state <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        if (byte_idx != last_idx) begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_byte  <= next_byte;
                            state    <= ST_SEND;
                        end else begin
                            state <= ST_WAIT_RSP;
                        end
                    end else if (tmr_expire) begin
                        rsp_status <= RSP_TIMEOUT;
                        rsp_byte   <= '0;
                        state      <= ST_REPORT;
                    end
                end
                ST_WAIT_RSP: begin
                    // A byte arriving on the expiry cycle still counts as a response.
                    if (rx_strobe) begin
                        rsp_status <= classify(cmd_q, rx_byte);
                        rsp_byte   <= rx_byte;
                        state      <= ST_REPORT;
                    end else if (tmr_expire) begin
                        rsp_status <= RSP_TIMEOUT;
                        rsp_byte   <= '0;
                        state      <= ST_REPORT;
                    end
                end
                ST_REPORT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
